// File: rtl/dispatch_pkg.sv
// Shared class encoding, entry layout and default widths for the dispatch queue.
// Declarations only: no latency and no flow control of its own.
// dq_entry_t describes one queue entry at the default widths.
package dispatch_pkg;

   localparam int DQ_FETCH_W = 4;
   localparam int DQ_DEPTH   = 8;
   localparam int DQ_NUM_FXU = 2;
   localparam int DQ_DATA_W  = 16;
   localparam int DQ_TAG_W   = 4;
   localparam int DQ_OPC_W   = 4;
   localparam int DQ_IMM_W   = 8;

   typedef enum logic [1:0] {
      FXU  = 2'd0,
      LSU  = 2'd1,
      BR   = 2'd2,
      NONE = 2'd3
   } fu_class_e;

   typedef struct packed {
      fu_class_e              cls;
      logic [DQ_OPC_W-1:0]    opcode;
      logic [DQ_IMM_W-1:0]    imm;
      logic                   a_rdy;
      logic [DQ_DATA_W-1:0]   a_val;
      logic [DQ_TAG_W-1:0]    a_tag;
      logic                   b_rdy;
      logic [DQ_DATA_W-1:0]   b_val;
      logic [DQ_TAG_W-1:0]    b_tag;
   } dq_entry_t;

endpackage

// File: rtl/dq_operand_wakeup.sv
// One operand slot of a queue entry: ready/value/tag register snooping the result bus.
// Latency: a matching broadcast is visible as rdy one cycle later, also when it coincides with the load.
// Backpressure: none; a load overrides snooping in the same cycle.
module dq_operand_wakeup
   import dispatch_pkg::*;
#(
   parameter int DATA_W = DQ_DATA_W,
   parameter int TAG_W  = DQ_TAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_rdy,
   input  logic [DATA_W-1:0] load_val,
   input  logic [TAG_W-1:0]  load_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_value,
   output logic              rdy,
   output logic [DATA_W-1:0] val,
   output logic [TAG_W-1:0]  tag
);

   logic load_hit;
   logic snoop_hit;

   assign load_hit  = cdb_valid && !load_rdy && (cdb_tag == load_tag);
   assign snoop_hit = cdb_valid && !rdy && (cdb_tag == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy <= 1'b0;
         val <= '0;
         tag <= '0;
      end else if (load) begin
         rdy <= load_rdy || load_hit;
         val <= load_hit ? cdb_value : load_val;
         tag <= load_tag;
      end else if (snoop_hit) begin
         rdy <= 1'b1;
         val <= cdb_value;
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: FETCH_W-wide enqueue, up to NUM_FU dispatches per cycle with ROB index allocation.
// Latency: an entry can dispatch the cycle after enqueue; optional CDB_BYPASS_EN forwards same-cycle results.
// Backpressure: in_ready needs FETCH_W free slots; dispatch stops at the first entry lacking a port or ROB slot.
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int FETCH_W = DQ_FETCH_W,
   parameter int DEPTH   = DQ_DEPTH,
   parameter int NUM_FXU = DQ_NUM_FXU,
   parameter int DATA_W  = DQ_DATA_W,
   parameter int TAG_W   = DQ_TAG_W,
   parameter int OPC_W   = DQ_OPC_W,
   parameter int IMM_W   = DQ_IMM_W,
   localparam int NUM_FU  = NUM_FXU + 2,
   localparam int ICNT_W  = $clog2(FETCH_W + 1),
   localparam int ALLOC_W = $clog2(NUM_FU + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ICNT_W-1:0]          in_count,
   input  logic [FETCH_W*2-1:0]       in_class,
   input  logic [FETCH_W*OPC_W-1:0]   in_opcode,
   input  logic [FETCH_W*IMM_W-1:0]   in_imm,
   input  logic [FETCH_W-1:0]         in_a_rdy,
   input  logic [FETCH_W-1:0]         in_b_rdy,
   input  logic [FETCH_W*DATA_W-1:0]  in_a_val,
   input  logic [FETCH_W*DATA_W-1:0]  in_b_val,
   input  logic [FETCH_W*TAG_W-1:0]   in_a_tag,
   input  logic [FETCH_W*TAG_W-1:0]   in_b_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_value,
   input  logic [TAG_W-1:0]           rob_tail,
   input  logic [TAG_W:0]             rob_free,
   output logic [ALLOC_W-1:0]         rob_alloc,
   output logic [NUM_FU-1:0]          fu_valid,
   input  logic [NUM_FU-1:0]          fu_ready,
   output logic [NUM_FU*TAG_W-1:0]    fu_rob_idx,
   output logic [NUM_FU*OPC_W-1:0]    fu_opcode,
   output logic [NUM_FU*IMM_W-1:0]    fu_imm,
   output logic [NUM_FU-1:0]          fu_a_rdy,
   output logic [NUM_FU*DATA_W-1:0]   fu_a_val,
   output logic [NUM_FU*TAG_W-1:0]    fu_a_tag,
   output logic [NUM_FU-1:0]          fu_b_rdy,
   output logic [NUM_FU*DATA_W-1:0]   fu_b_val,
   output logic [NUM_FU*TAG_W-1:0]    fu_b_tag
);

   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int SLOT_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
   localparam int LSU_PORT = NUM_FXU;
   localparam int BR_PORT  = NUM_FXU + 1;

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   fu_class_e         cls    [DEPTH];
   logic [OPC_W-1:0]  opcode [DEPTH];
   logic [IMM_W-1:0]  imm    [DEPTH];
   logic [DEPTH-1:0]  a_rdy;
   logic [DEPTH-1:0]  b_rdy;
   logic [DATA_W-1:0] a_val  [DEPTH];
   logic [DATA_W-1:0] b_val  [DEPTH];
   logic [TAG_W-1:0]  a_tag  [DEPTH];
   logic [TAG_W-1:0]  b_tag  [DEPTH];

   logic              enq;
   logic [ICNT_W-1:0] enq_n;
   logic [DEPTH-1:0]  load;
   logic [SLOT_W-1:0] load_slot [DEPTH];

   logic [NUM_FU-1:0] d_valid;
   logic [NUM_FU-1:0] d_a_rdy;
   logic [NUM_FU-1:0] d_b_rdy;
   logic [TAG_W-1:0]  d_rob   [NUM_FU];
   logic [OPC_W-1:0]  d_opc   [NUM_FU];
   logic [IMM_W-1:0]  d_imm   [NUM_FU];
   logic [DATA_W-1:0] d_a_val [NUM_FU];
   logic [DATA_W-1:0] d_b_val [NUM_FU];
   logic [TAG_W-1:0]  d_a_tag [NUM_FU];
   logic [TAG_W-1:0]  d_b_tag [NUM_FU];
   logic [ALLOC_W-1:0] n_disp;

   // Occupancy before this cycle's dispatch keeps enqueue independent of fu_ready.
   assign in_ready = int'(count) <= (DEPTH - FETCH_W);
   assign enq      = in_valid && in_ready && !flush;
   assign enq_n    = (int'(in_count) > FETCH_W) ? ICNT_W'(FETCH_W) : in_count;

   always_comb begin
      load = '0;
      for (int e = 0; e < DEPTH; e++) begin
         load_slot[e] = '0;
      end
      for (int i = 0; i < FETCH_W; i++) begin
         if (enq && (i < int'(enq_n))) begin
            load[PTR_W'((int'(tail) + i) % DEPTH)]      = 1'b1;
            load_slot[PTR_W'((int'(tail) + i) % DEPTH)] = SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < DEPTH; e++) begin
            cls[e]    <= NONE;
            opcode[e] <= '0;
            imm[e]    <= '0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (load[e]) begin
               cls[e]    <= fu_class_e'(in_class[int'(load_slot[e])*2 +: 2]);
               opcode[e] <= in_opcode[int'(load_slot[e])*OPC_W +: OPC_W];
               imm[e]    <= in_imm[int'(load_slot[e])*IMM_W +: IMM_W];
            end
         end
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      dq_operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_op_a (
         .clk       (clk),
         .rst       (rst),
         .load      (load[e]),
         .load_rdy  (in_a_rdy[load_slot[e]]),
         .load_val  (in_a_val[int'(load_slot[e])*DATA_W +: DATA_W]),
         .load_tag  (in_a_tag[int'(load_slot[e])*TAG_W +: TAG_W]),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_value (cdb_value),
         .rdy       (a_rdy[e]),
         .val       (a_val[e]),
         .tag       (a_tag[e])
      );
      dq_operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_op_b (
         .clk       (clk),
         .rst       (rst),
         .load      (load[e]),
         .load_rdy  (in_b_rdy[load_slot[e]]),
         .load_val  (in_b_val[int'(load_slot[e])*DATA_W +: DATA_W]),
         .load_tag  (in_b_tag[int'(load_slot[e])*TAG_W +: TAG_W]),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_value (cdb_value),
         .rdy       (b_rdy[e]),
         .val       (b_val[e]),
         .tag       (b_tag[e])
      );
   end

   // In-order walk from head; the first entry that cannot issue ends the prefix.
   always_comb begin
      logic              stop;
      logic              found;
      logic [NUM_FU-1:0] taken;
      logic [PTR_W-1:0]  idx;
      int                p;

      stop   = flush;
      taken  = '0;
      n_disp = '0;
      for (int j = 0; j < NUM_FU; j++) begin
         d_valid[j] = 1'b0;
         d_a_rdy[j] = 1'b0;
         d_b_rdy[j] = 1'b0;
         d_rob[j]   = '0;
         d_opc[j]   = '0;
         d_imm[j]   = '0;
         d_a_val[j] = '0;
         d_b_val[j] = '0;
         d_a_tag[j] = '0;
         d_b_tag[j] = '0;
      end

      for (int k = 0; k < NUM_FU; k++) begin
         idx   = PTR_W'((int'(head) + k) % DEPTH);
         found = 1'b0;
         p     = 0;
         if (!stop && (k < int'(count)) && (k < int'(rob_free))) begin
            case (cls[idx])
               FXU: begin
                  for (int j = NUM_FXU - 1; j >= 0; j--) begin
                     if (fu_ready[j] && !taken[j]) begin
                        found = 1'b1;
                        p     = j;
                     end
                  end
               end
               LSU: begin
                  if (fu_ready[LSU_PORT] && !taken[LSU_PORT]) begin
                     found = 1'b1;
                     p     = LSU_PORT;
                  end
               end
               BR: begin
                  if (fu_ready[BR_PORT] && !taken[BR_PORT]) begin
                     found = 1'b1;
                     p     = BR_PORT;
                  end
               end
               default: found = 1'b0;
            endcase
         end

         if (found) begin
            taken[p]   = 1'b1;
            d_valid[p] = 1'b1;
            d_rob[p]   = TAG_W'(int'(rob_tail) + k);
            d_opc[p]   = opcode[idx];
            d_imm[p]   = imm[idx];
            d_a_rdy[p] = a_rdy[idx];
            d_a_val[p] = a_val[idx];
            d_a_tag[p] = a_tag[idx];
            d_b_rdy[p] = b_rdy[idx];
            d_b_val[p] = b_val[idx];
            d_b_tag[p] = b_tag[idx];
`ifdef CDB_BYPASS_EN
            if (!a_rdy[idx] && cdb_valid && (cdb_tag == a_tag[idx])) begin
               d_a_rdy[p] = 1'b1;
               d_a_val[p] = cdb_value;
            end
            if (!b_rdy[idx] && cdb_valid && (cdb_tag == b_tag[idx])) begin
               d_b_rdy[p] = 1'b1;
               d_b_val[p] = cdb_value;
            end
`endif
            n_disp = n_disp + ALLOC_W'(1);
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head <= PTR_W'((int'(head) + int'(n_disp)) % DEPTH);
         if (enq) begin
            tail <= PTR_W'((int'(tail) + int'(enq_n)) % DEPTH);
         end
         count <= CNT_W'(int'(count) + (enq ? int'(enq_n) : 0) - int'(n_disp));
      end
   end

   assign fu_valid  = d_valid;
   assign fu_a_rdy  = d_a_rdy;
   assign fu_b_rdy  = d_b_rdy;
   assign rob_alloc = n_disp;

   for (genvar j = 0; j < NUM_FU; j++) begin : g_port
      assign fu_rob_idx[j*TAG_W +: TAG_W]  = d_rob[j];
      assign fu_opcode[j*OPC_W +: OPC_W]   = d_opc[j];
      assign fu_imm[j*IMM_W +: IMM_W]      = d_imm[j];
      assign fu_a_val[j*DATA_W +: DATA_W]  = d_a_val[j];
      assign fu_a_tag[j*TAG_W +: TAG_W]    = d_a_tag[j];
      assign fu_b_val[j*DATA_W +: DATA_W]  = d_b_val[j];
      assign fu_b_tag[j*TAG_W +: TAG_W]    = d_b_tag[j];
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: per-cycle vector table plus wakeup, bypass and reset sequences.
// Default parameters; port 0/1 = FXU, 2 = LSU, 3 = BR.
module tb_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_count;
   logic [7:0]  in_class;
   logic [15:0] in_opcode;
   logic [31:0] in_imm;
   logic [3:0]  in_a_rdy, in_b_rdy;
   logic [63:0] in_a_val, in_b_val;
   logic [15:0] in_a_tag, in_b_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [15:0] cdb_value;
   logic [3:0]  rob_tail;
   logic [4:0]  rob_free;
   logic [2:0]  rob_alloc;
   logic [3:0]  fu_valid, fu_ready;
   logic [15:0] fu_rob_idx, fu_opcode;
   logic [31:0] fu_imm;
   logic [3:0]  fu_a_rdy, fu_b_rdy;
   logic [63:0] fu_a_val, fu_b_val;
   logic [15:0] fu_a_tag, fu_b_tag;

   int n_checks = 0;
   int n_fail   = 0;

   dispatch_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
      .in_class(in_class), .in_opcode(in_opcode), .in_imm(in_imm),
      .in_a_rdy(in_a_rdy), .in_b_rdy(in_b_rdy),
      .in_a_val(in_a_val), .in_b_val(in_b_val),
      .in_a_tag(in_a_tag), .in_b_tag(in_b_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .rob_tail(rob_tail), .rob_free(rob_free), .rob_alloc(rob_alloc),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_rob_idx(fu_rob_idx), .fu_opcode(fu_opcode), .fu_imm(fu_imm),
      .fu_a_rdy(fu_a_rdy), .fu_a_val(fu_a_val), .fu_a_tag(fu_a_tag),
      .fu_b_rdy(fu_b_rdy), .fu_b_val(fu_b_val), .fu_b_tag(fu_b_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        in_valid;
      logic [2:0]  in_count;
      logic [7:0]  in_class;
      logic [15:0] in_opcode;
      logic [3:0]  fu_ready;
      logic [3:0]  rob_tail;
      logic [4:0]  rob_free;
      logic        exp_in_ready;
      logic [3:0]  exp_fu_valid;
      logic [2:0]  exp_alloc;
      logic [15:0] exp_rob;
      logic [15:0] exp_opc;
   } vec_t;

   localparam int NV = 26;
   vec_t vt [NV];

   function automatic vec_t mk(input logic fl, input logic iv, input logic [2:0] ic,
                               input logic [7:0] cl, input logic [15:0] op,
                               input logic [3:0] rdy, input logic [3:0] rt, input logic [4:0] rf,
                               input logic eir, input logic [3:0] efv, input logic [2:0] eal,
                               input logic [15:0] erob, input logic [15:0] eopc);
      vec_t v;
      v.flush = fl; v.in_valid = iv; v.in_count = ic; v.in_class = cl; v.in_opcode = op;
      v.fu_ready = rdy; v.rob_tail = rt; v.rob_free = rf;
      v.exp_in_ready = eir; v.exp_fu_valid = efv; v.exp_alloc = eal;
      v.exp_rob = erob; v.exp_opc = eopc;
      return v;
   endfunction

   function automatic logic [15:0] nib_mask(input logic [3:0] v);
      logic [15:0] m;
      for (int i = 0; i < 4; i++) m[4*i +: 4] = {4{v[i]}};
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; in_count = '0; in_class = '0; in_opcode = '0;
      in_a_rdy = 4'hF; in_b_rdy = 4'hF; in_a_val = '0; in_b_val = '0;
      in_a_tag = '0; in_b_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
      fu_ready = 4'h0; rob_tail = '0; rob_free = 5'd16;
   endtask

   task automatic drive(input vec_t v);
      idle();
      flush = v.flush; in_valid = v.in_valid; in_count = v.in_count; in_class = v.in_class;
      in_opcode = v.in_opcode; fu_ready = v.fu_ready; rob_tail = v.rob_tail; rob_free = v.rob_free;
   endtask

   task automatic enq1(input logic [3:0] opc, input logic ar, input logic [3:0] at,
                       input logic br, input logic [3:0] bt, input logic [15:0] bv);
      idle();
      in_valid = 1'b1; in_count = 3'd1; in_class = 8'h00; in_opcode = {12'h0, opc};
      in_a_rdy = {3'b111, ar}; in_a_tag = {12'h0, at};
      in_b_rdy = {3'b111, br}; in_b_tag = {12'h0, bt}; in_b_val = {48'h0, bv};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_imm = 32'h44332211;
      // flush in_valid count class opcode fu_rdy tail free | in_ready fu_valid alloc rob opc
      vt[0]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  0, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[1]  = mk(0, 1, 4, 8'h00, 16'h4321, 4'b0011, 14, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[2]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011, 14, 16, 1, 4'b0011, 2, 16'h00FE, 16'h0021);
      vt[3]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  0, 16, 1, 4'b0011, 2, 16'h0010, 16'h0043);
      vt[4]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  2, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[5]  = mk(0, 1, 4, 8'h08, 16'h8765, 4'b0111,  2, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[6]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0111,  2, 16, 1, 4'b0001, 1, 16'h0002, 16'h0005);
      vt[7]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  3, 16, 1, 4'b1011, 3, 16'h3054, 16'h6087);
      vt[8]  = mk(0, 1, 4, 8'h24, 16'hCBA9, 4'b1111,  6,  1, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[9]  = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  6,  1, 1, 4'b0001, 1, 16'h0006, 16'h0009);
      vt[10] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  7,  0, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[11] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  7, 16, 1, 4'b1101, 3, 16'h8709, 16'hBA0C);
      vt[12] = mk(0, 1, 4, 8'h00, 16'h4321, 4'b0000,  0, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[13] = mk(0, 1, 4, 8'h00, 16'h8765, 4'b0000,  0, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[14] = mk(0, 1, 4, 8'h00, 16'hFFFF, 4'b0000,  0, 16, 0, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[15] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  0, 16, 0, 4'b0011, 2, 16'h0010, 16'h0021);
      vt[16] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  2, 16, 0, 4'b0011, 2, 16'h0032, 16'h0043);
      vt[17] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0000,  4, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[18] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  4, 16, 1, 4'b0011, 2, 16'h0054, 16'h0065);
      vt[19] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  6, 16, 1, 4'b0011, 2, 16'h0076, 16'h0087);
      vt[20] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b1111,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[21] = mk(0, 1, 2, 8'h00, 16'h0021, 4'b0000,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[22] = mk(1, 1, 1, 8'h00, 16'h0003, 4'b0011,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[23] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[24] = mk(0, 1, 0, 8'h00, 16'h0005, 4'b0011,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);
      vt[25] = mk(0, 0, 0, 8'h00, 16'h0000, 4'b0011,  8, 16, 1, 4'b0000, 0, 16'h0000, 16'h0000);

      idle();
      fu_ready = 4'hF;
      rst = 1'b1;
      #3;
      check("reset in_ready", in_ready, 1);
      check("reset fu_valid", fu_valid, 0);
      check("reset rob_alloc", rob_alloc, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         logic [15:0] m;
         drive(vt[i]);
         m = nib_mask(vt[i].exp_fu_valid);
         @(negedge clk);
         check($sformatf("v%0d in_ready", i), in_ready, vt[i].exp_in_ready);
         check($sformatf("v%0d fu_valid", i), fu_valid, vt[i].exp_fu_valid);
         check($sformatf("v%0d rob_alloc", i), rob_alloc, vt[i].exp_alloc);
         check($sformatf("v%0d fu_rob_idx", i), fu_rob_idx & m, vt[i].exp_rob & m);
         check($sformatf("v%0d fu_opcode", i), fu_opcode & m, vt[i].exp_opc & m);
         @(posedge clk); #1;
      end

      // Wakeup on a later cycle, seen at the next dispatch
      enq1(4'hD, 1'b0, 4'd5, 1'b1, 4'd0, 16'hBEEF);
      @(posedge clk); #1;
      idle(); cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 16'h1234;
      @(negedge clk);
      check("wake hold fu_valid", fu_valid, 4'b0000);
      @(posedge clk); #1;
      idle(); fu_ready = 4'b0001;
      @(negedge clk);
      check("wake fu_valid", fu_valid, 4'b0001);
      check("wake opcode", fu_opcode[3:0], 4'hD);
      check("wake imm", fu_imm[7:0], 8'h11);
      check("wake a_rdy", fu_a_rdy[0], 1'b1);
      check("wake a_val", fu_a_val[15:0], 16'h1234);
      check("wake b_rdy", fu_b_rdy[0], 1'b1);
      check("wake b_val", fu_b_val[15:0], 16'hBEEF);
      @(posedge clk); #1;

      // Result broadcast in the dispatch cycle itself
      enq1(4'hE, 1'b0, 4'd7, 1'b1, 4'd0, 16'h0000);
      @(posedge clk); #1;
      idle(); fu_ready = 4'b0001; cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 16'h5A5A;
      @(negedge clk);
      check("bypass fu_valid", fu_valid, 4'b0001);
`ifdef CDB_BYPASS_EN
      check("bypass a_rdy", fu_a_rdy[0], 1'b1);
      check("bypass a_val", fu_a_val[15:0], 16'h5A5A);
`else
      check("bypass a_rdy", fu_a_rdy[0], 1'b0);
      check("bypass a_tag", fu_a_tag[3:0], 4'd7);
`endif
      @(posedge clk); #1;

      // Broadcast coinciding with enqueue; operand B tag does not match
      enq1(4'hF, 1'b0, 4'd9, 1'b0, 4'd3, 16'h0000);
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 16'h0F0F;
      @(posedge clk); #1;
      idle(); fu_ready = 4'b0001;
      @(negedge clk);
      check("enqcap fu_valid", fu_valid, 4'b0001);
      check("enqcap a_rdy", fu_a_rdy[0], 1'b1);
      check("enqcap a_val", fu_a_val[15:0], 16'h0F0F);
      check("enqcap b_rdy", fu_b_rdy[0], 1'b0);
      check("enqcap b_tag", fu_b_tag[3:0], 4'd3);
      @(posedge clk); #1;

      // Asynchronous reset while two entries are dispatching
      idle(); in_valid = 1'b1; in_count = 3'd2; in_opcode = 16'h0021;
      @(posedge clk); #1;
      idle(); fu_ready = 4'b0011;
      #2;
      check("prerst fu_valid", fu_valid, 4'b0011);
      rst = 1'b1;
      #1;
      check("rst fu_valid", fu_valid, 4'b0000);
      check("rst rob_alloc", rob_alloc, 0);
      check("rst in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("postrst fu_valid", fu_valid, 4'b0000);
      check("postrst rob_alloc", rob_alloc, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
